// File: rtl/ff_pkg.sv
// Shared definitions for the modular add/subtract unit: curve25519 modulus,
// mode encoding, controller state type and limb-count helper.
package ff_pkg;

    localparam logic [254:0] P25519   = {{247{1'b1}}, 8'b1110_1101};
    localparam logic         MODE_SUB = 1'b0;
    localparam logic         MODE_ADD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Limbs needed to hold W+1 bits, so an add never loses its carry.
    function automatic int calc_nl(input int w, input int lw);
        return (w + lw) / lw;
    endfunction

endpackage

// File: rtl/ff_limb_addsub.sv
// One LW-bit limb of an add/subtract chain; cout is the carry (add) or the
// borrow (subtract) passed on to the next limb.
module ff_limb_addsub
    import ff_pkg::*;
#(
    parameter int LW = 64
) (
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    input  logic          cin,
    input  logic          mode,
    output logic [LW-1:0] sum,
    output logic          cout
);

    logic [LW:0] res_s;

    // Bit LW of the widened difference is set exactly when it went negative
    always_comb begin
        res_s = {(LW+1){1'b0}};
        if (mode == MODE_ADD) begin
            res_s = {1'b0, a} + {1'b0, b} + {{LW{1'b0}}, cin};
        end else begin
            res_s = {1'b0, a} - {1'b0, b} - {{LW{1'b0}}, cin};
        end
    end

    assign sum  = res_s[LW-1:0];
    assign cout = res_s[LW];

endmodule

// File: rtl/ff_addsub.sv
// Limb-serial modular add/subtract (a +/- b mod P), one limb per cycle.
// Optional FF_ADDSUB_RANGE_CHECK_EN adds an err output flagging non-canonical operands.
module ff_addsub
    import ff_pkg::*;
#(
    parameter int           W  = 255,
    parameter int           LW = 64,
    parameter logic [W-1:0] P  = W'(P25519)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] out,
    output logic         done,
    output logic         busy
`ifdef FF_ADDSUB_RANGE_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam int                    NL      = calc_nl(W, LW);
    localparam int                    DW      = NL * LW;
    localparam int                    IW      = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [IW-1:0]         LAST_I  = IW'(NL - 1);
    localparam logic [IW-1:0]         ONE_I   = IW'(1);
    localparam logic [NL-1:0][LW-1:0] P_LIMBS = DW'(P);

    state_t                  state_r, state_nx_s;
    logic [NL-1:0][LW-1:0]   a_r, b_r, raw_r, corr_r;
    logic                    mode_r, c1_r, c2_r, sel_corr_r;
    logic [IW-1:0]           k_r, idx2_s;
    logic [LW-1:0]           s1_sum_s, s2_sum_s;
    logic                    s1_cout_s, s2_cout_s;
    logic [W-1:0]            out_r;
    logic                    done_r, busy_r;

    // Stage 1: A +/- B, limb k
    ff_limb_addsub #(.LW(LW)) u_stage1 (
        .a    (a_r[k_r]),
        .b    (b_r[k_r]),
        .cin  (c1_r),
        .mode (mode_r),
        .sum  (s1_sum_s),
        .cout (s1_cout_s)
    );

    // Stage 2 applies the opposite operation with P, one limb behind stage 1
    ff_limb_addsub #(.LW(LW)) u_stage2 (
        .a    (raw_r[idx2_s]),
        .b    (P_LIMBS[idx2_s]),
        .cin  (c2_r),
        .mode (~mode_r),
        .sum  (s2_sum_s),
        .cout (s2_cout_s)
    );

    // Stage-2 limb index: trails the counter, pinned to the top limb in FIX
    always_comb begin
        idx2_s = k_r - ONE_I;
        if (state_r == ST_FIX) begin
            idx2_s = LAST_I;
        end else begin
            idx2_s = k_r - ONE_I;
        end
    end

    // Controller next-state
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (k_r == LAST_I) begin
                    state_nx_s = ST_FIX;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FIX:  state_nx_s = ST_DONE;
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, operand latch, limb pipeline and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            a_r        <= {DW{1'b0}};
            b_r        <= {DW{1'b0}};
            raw_r      <= {DW{1'b0}};
            corr_r     <= {DW{1'b0}};
            mode_r     <= 1'b0;
            c1_r       <= 1'b0;
            c2_r       <= 1'b0;
            sel_corr_r <= 1'b0;
            k_r        <= {IW{1'b0}};
            out_r      <= {W{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r    <= {{(DW-W){1'b0}}, a_i};
                        b_r    <= {{(DW-W){1'b0}}, b_i};
                        mode_r <= mode;
                        c1_r   <= 1'b0;
                        c2_r   <= 1'b0;
                        k_r    <= {IW{1'b0}};
                        busy_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    raw_r[k_r] <= s1_sum_s;
                    c1_r       <= s1_cout_s;
                    k_r        <= k_r + ONE_I;
                    if (k_r != {IW{1'b0}}) begin
                        corr_r[idx2_s] <= s2_sum_s;
                        c2_r           <= s2_cout_s;
                    end
                end
                ST_FIX: begin
                    corr_r[idx2_s] <= s2_sum_s;
                    c2_r           <= s2_cout_s;
                    // Sub: fix up when A<B; add: take raw-P unless it borrowed
                    sel_corr_r     <= (mode_r == MODE_ADD) ? ~s2_cout_s : c1_r;
                end
                ST_DONE: begin
                    out_r  <= sel_corr_r ? W'(corr_r) : W'(raw_r);
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign out  = out_r;
    assign done = done_r;
    assign busy = busy_r;

`ifdef FF_ADDSUB_RANGE_CHECK_EN
    logic err_r;

    // Non-canonical operand flag, updated together with the result
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            err_r <= (a_r >= P_LIMBS) || (b_r >= P_LIMBS);
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_ff_addsub.sv
// Randomised self-checking bench for ff_addsub: a default 255-bit instance and
// a small W=7/LW=4/P=127 instance, both against plain modular arithmetic.
module tb_ff_addsub;

    localparam int             BNL  = (255 + 1 + 63) / 64;
    localparam int             BLAT = BNL + 2;
    localparam int             SLAT = (7 + 1 + 3) / 4 + 2;
    localparam logic [255:0]   PB   = (256'd1 << 255) - 256'd19;
    localparam logic [254:0]   PF   = PB[254:0];

    logic         clk = 1'b0;
    logic         rst;
    logic         start, mode, done, busy;
    logic [254:0] a_i, b_i, out;
    logic         s_start, s_mode, s_done, s_busy;
    logic [6:0]   s_a, s_b, s_out;
`ifdef FF_ADDSUB_RANGE_CHECK_EN
    logic         err, s_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ff_addsub dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a_i(a_i), .b_i(b_i),
        .out(out), .done(done), .busy(busy)
`ifdef FF_ADDSUB_RANGE_CHECK_EN
        , .err(err)
`endif
    );

    ff_addsub #(.W(7), .LW(4), .P(7'd127)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .a_i(s_a), .b_i(s_b),
        .out(s_out), .done(s_done), .busy(s_busy)
`ifdef FF_ADDSUB_RANGE_CHECK_EN
        , .err(s_err)
`endif
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [254:0] rnd_fe();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        v[255] = 1'b0;
        if (v >= PB) v = v - PB;
        return v[254:0];
    endfunction

    function automatic logic [254:0] ref_big(input logic m, input logic [254:0] a, input logic [254:0] b);
        logic [255:0] s;
        if (m) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= PB) s = s - PB;
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = PB - ({1'b0, b} - {1'b0, a});
        end
        return s[254:0];
    endfunction

    function automatic logic [6:0] ref_small(input logic m, input int a, input int b);
        int r;
        r = m ? (a + b) % 127 : (a - b + 127) % 127;
        return r[6:0];
    endfunction

    // act: 0 normal, 1 second start two cycles after acceptance, 2 reset at limb 2
    task automatic run_big(input logic m, input logic [254:0] a, input logic [254:0] b, input int act,
                           output logic [254:0] res, output logic [254:0] res_end,
                           output int lat, output int npulse, output int busy_bad);
        int busy_until;
        busy_until = (act == 2) ? 3 : BLAT;
        res = '0; lat = -1; npulse = 0; busy_bad = 0;
        @(negedge clk); start = 1'b1; mode = m; a_i = a; b_i = b;
        @(negedge clk); start = 1'b0; mode = ~m; a_i = rnd_fe(); b_i = rnd_fe();
        for (int e = 0; e <= 12; e++) begin
            if (e > 0) @(negedge clk);
            if (done === 1'b1) begin
                npulse++;
                if (lat < 0) begin lat = e; res = out; end
            end
            if (busy !== (e < busy_until)) busy_bad++;
            if (act == 1 && e == 2) begin start = 1'b1; a_i = rnd_fe(); b_i = rnd_fe(); mode = ~m; end
            if (act == 2 && e == 2) rst = 1'b1;
            if (e == 3) begin start = 1'b0; rst = 1'b0; end
        end
        res_end = out;
    endtask

    task automatic big_op(input string tag, input logic m, input logic [254:0] a, input logic [254:0] b);
        logic [254:0] res, res_end, exp;
        int lat, np, bb;
        run_big(m, a, b, 0, res, res_end, lat, np, bb);
        exp = ref_big(m, a, b);
        check({tag, "_out"}, 256'(res), 256'(exp));
        check({tag, "_lat"}, 256'(lat), 256'(BLAT));
        check({tag, "_pulses"}, 256'(np), 256'd1);
        check({tag, "_busy"}, 256'(bb), 256'd0);
        check({tag, "_hold"}, 256'(res_end), 256'(exp));
    endtask

    task automatic run_small(input logic m, input logic [6:0] a, input logic [6:0] b,
                             output logic [6:0] res, output int lat, output logic e_flag);
        lat = -1; res = '0; e_flag = 1'b0;
        @(negedge clk); s_start = 1'b1; s_mode = m; s_a = a; s_b = b;
        @(negedge clk); s_start = 1'b0; s_a = 7'($urandom_range(0, 126)); s_b = 7'($urandom_range(0, 126));
        for (int e = 0; e <= 8; e++) begin
            if (e > 0) @(negedge clk);
            if (s_done === 1'b1 && lat < 0) begin
                lat = e;
                res = s_out;
`ifdef FF_ADDSUB_RANGE_CHECK_EN
                e_flag = s_err;
`endif
            end
        end
    endtask

    initial begin
        logic [254:0] res, res_end, x, ra, rb;
        logic [6:0]   sres;
        logic         sflag, m;
        int           lat, np, bb, sa, sb;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a_i = '0; b_i = '0;
        s_start = 1'b0; s_mode = 1'b0; s_a = '0; s_b = '0;
        repeat (3) @(negedge clk);
        check("rst_out", 256'(out), 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_s_out", 256'(s_out), 256'd0);
        check("rst_s_busy", 256'(s_busy), 256'd0);
`ifdef FF_ADDSUB_RANGE_CHECK_EN
        check("rst_err", 256'(err), 256'd0);
`endif
        rst = 1'b0;

        big_op("sub_5_3", 1'b0, 255'd5, 255'd3);
        big_op("sub_3_5", 1'b0, 255'd3, 255'd5);
        check("sub_3_5_const", 256'(out), PB - 256'd2);
        big_op("add_pm1_2", 1'b1, PF - 255'd1, 255'd2);
        big_op("add_pm1_1", 1'b1, PF - 255'd1, 255'd1);
        x = rnd_fe();
        big_op("sub_equal", 1'b0, x, x);
        big_op("add_to_p", 1'b1, x, PF - x);
        big_op("add_zero", 1'b1, 255'd0, 255'd0);
`ifdef FF_ADDSUB_RANGE_CHECK_EN
        check("big_err", 256'(err), 256'd0);
`endif

        ra = rnd_fe(); rb = rnd_fe();
        run_big(1'b1, ra, rb, 1, res, res_end, lat, np, bb);
        check("restart_out", 256'(res), 256'(ref_big(1'b1, ra, rb)));
        check("restart_lat", 256'(lat), 256'(BLAT));
        check("restart_pulses", 256'(np), 256'd1);
        check("restart_busy", 256'(bb), 256'd0);

        ra = rnd_fe(); rb = rnd_fe();
        run_big(1'b0, ra, rb, 2, res, res_end, lat, np, bb);
        check("abort_pulses", 256'(np), 256'd0);
        check("abort_out", 256'(res_end), 256'd0);
        check("abort_busy", 256'(bb), 256'd0);
        check("abort_state", 256'(dut.state_r), 256'(ff_pkg::ST_IDLE));
        big_op("after_abort", 1'b0, ra, rb);

        for (int i = 0; i < 10; i++) begin
            m = 1'($urandom_range(0, 1));
            big_op("rand_big", m, rnd_fe(), rnd_fe());
        end

        for (int i = 0; i < 16; i++) begin
            m  = 1'($urandom_range(0, 1));
            sa = int'($urandom_range(0, 126));
            sb = int'($urandom_range(0, 126));
            if (i == 0) begin m = 1'b1; sa = 126; sb = 1; end
            if (i == 1) begin m = 1'b0; sa = 0;   sb = 126; end
            run_small(m, sa[6:0], sb[6:0], sres, lat, sflag);
            check("small_out", 256'(sres), 256'(ref_small(m, sa, sb)));
            check("small_lat", 256'(lat), 256'(SLAT));
        end

`ifdef FF_ADDSUB_RANGE_CHECK_EN
        run_small(1'b1, 7'd127, 7'd0, sres, lat, sflag);
        check("range_err_set", 256'(sflag), 256'd1);
        check("range_out", 256'(sres), 256'(ref_small(1'b1, 127, 0)));
        run_small(1'b1, 7'd100, 7'd27, sres, lat, sflag);
        check("range_err_clr", 256'(sflag), 256'd0);
        check("range_out_zero", 256'(sres), 256'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
